// File: rtl/cacheline_burst_adaptor_if.sv
// Bundles the cache line port and the memory burst port of the line/burst adaptor.
// Ports: cache side address_i/read_i/write_i/line_i in, line_o/resp_o out;
//        memory side address_o/read_o/write_o/burst_o out, burst_i/resp_i in.
// slave modport is the adaptor's view; master modport is the cache+memory view.
interface cacheline_burst_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  // cache side
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic                   resp_o;
  // memory side
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits a cache line write into BEATS memory bursts and assembles BEATS read bursts into a line.
// Latency: request accepted in cycle 0, read_o/write_o from cycle 1, resp_o one cycle after last resp_i.
// Backpressure: memory paces beats with resp_i (gaps hold the count); cache holds its request until resp_o.
// Ports: clk, rst (async active-low), bus (slave modport: cache line port + memory burst port).
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic                      clk,
  input logic                      rst,
  cacheline_burst_adaptor_if.slave bus
);

  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]                         state_q;
  logic [BEAT_BITS-1:0]               count_q;
  logic [ADDR_WIDTH-1:0]              addr_q;
  // Beat k of the line lives in line_q[k], i.e. bits BURST_WIDTH*k upward.
  logic [BEATS-1:0][BURST_WIDTH-1:0]  line_q;
  // Separate read-result register so writes (which reuse line_q) never disturb line_o.
  logic [LINE_WIDTH-1:0]              line_out_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0]  rd_line;

  // Line as it will look once the current read beat is merged in; captured on the final beat.
  always_comb begin
    rd_line          = line_q;
    rd_line[count_q] = bus.burst_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      line_q     <= '0;
      line_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.read_i) begin
            state_q <= RD;
            addr_q  <= {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end else if (bus.write_i) begin
            state_q <= WR;
            addr_q  <= {bus.address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            line_q  <= bus.line_i;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            line_q[count_q] <= bus.burst_i;
            count_q         <= count_q + 1'b1;
            if (count_q == LAST_BEAT) begin
              state_q    <= DONE;
              line_out_q <= rd_line;
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_BEAT) begin
              state_q <= DONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_o    = (state_q == RD);
  assign bus.write_o   = (state_q == WR);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = (state_q == RD || state_q == WR) ? addr_q : '0;
  assign bus.burst_o   = (state_q == WR) ? line_q[count_q] : '0;
  assign bus.line_o    = line_out_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cacheline_burst_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) bus ();

  cacheline_burst_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  logic [63:0]  rd_beats [4];
  logic [63:0]  gp_beats [4];
  logic [63:0]  bh_beats [4];
  logic [63:0]  r2_beats [4];
  logic [255:0] rd_line_exp;
  logic [255:0] gp_line_exp;
  logic [255:0] bh_line_exp;
  logic [255:0] r2_line_exp;
  logic [255:0] wr_line;
  logic [255:0] wr_line2;
  logic [63:0]  wr_exp [4];
  logic [63:0]  wr_exp_b [4];
  logic [6:0]   gap_pat;

  initial begin
    total = 0;
    bad   = 0;
    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    rd_line_exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    gp_beats = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                 64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738};
    gp_line_exp = {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                   64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708};
    bh_beats = '{64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002,
                 64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0004};
    bh_line_exp = {64'hA0A0_0000_0000_0004, 64'hA0A0_0000_0000_0003,
                   64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0001};
    r2_beats = '{64'h5555_0000_0000_0000, 64'h6666_0000_0000_0000,
                 64'h7777_0000_0000_0000, 64'h8888_0000_0000_0000};
    r2_line_exp = {64'h8888_0000_0000_0000, 64'h7777_0000_0000_0000,
                   64'h6666_0000_0000_0000, 64'h5555_0000_0000_0000};
    wr_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wr_exp  = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    wr_line2 = {64'h0F0F_0F0F_0F0F_0F04, 64'h0F0F_0F0F_0F0F_0F03,
                64'h0F0F_0F0F_0F0F_0F02, 64'h0F0F_0F0F_0F0F_0F01};
    wr_exp_b = '{64'h0F0F_0F0F_0F0F_0F01, 64'h0F0F_0F0F_0F0F_0F02,
                 64'h0F0F_0F0F_0F0F_0F03, 64'h0F0F_0F0F_0F0F_0F04};
    gap_pat = 7'b1011001; // bit 0 first: 1,0,0,1,1,0,1

    rst           = 1'b0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    step();
    step();

    // ---------------- reset state
    check("rst_read_o",  256'(bus.read_o),    256'(0));
    check("rst_write_o", 256'(bus.write_o),   256'(0));
    check("rst_resp_o",  256'(bus.resp_o),    256'(0));
    check("rst_addr_o",  256'(bus.address_o), 256'(0));
    check("rst_burst_o", 256'(bus.burst_o),   256'(0));
    check("rst_line_o",  bus.line_o,          256'(0));
    rst = 1'b1;

    // resp_i while idle must not advance the beat counter
    bus.resp_i = 1'b1;
    step();
    step();
    check("idle_resp_read_o", 256'(bus.read_o), 256'(0));
    bus.resp_i = 1'b0;

    // ---------------- plain read
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_1234;
    step();
    check("rd_read_o", 256'(bus.read_o),    256'(1));
    check("rd_addr_o", 256'(bus.address_o), 256'(32'h0000_1220));
    check("rd_write_o", 256'(bus.write_o),  256'(0));
    for (int k = 0; k < 4; k++) begin
      check("rd_no_resp", 256'(bus.resp_o), 256'(0));
      bus.resp_i  = 1'b1;
      bus.burst_i = rd_beats[k];
      step();
    end
    bus.resp_i = 1'b0;
    check("rd_resp_o",     256'(bus.resp_o), 256'(1));
    check("rd_read_drop",  256'(bus.read_o), 256'(0));
    check("rd_line_o",     bus.line_o,       rd_line_exp);
    bus.read_i = 1'b0;
    step();
    check("rd_resp_pulse", 256'(bus.resp_o), 256'(0));
    check("rd_line_hold",  bus.line_o,       rd_line_exp);

    // ---------------- plain write; input changes after accept are ignored
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_0040;
    bus.line_i    = wr_line;
    step();
    bus.line_i    = '0;
    bus.address_i = 32'hFFFF_FFFF;
    check("wr_write_o", 256'(bus.write_o),   256'(1));
    check("wr_addr_o",  256'(bus.address_o), 256'(32'h0000_0040));
    check("wr_read_o",  256'(bus.read_o),    256'(0));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_burst%0d", k), 256'(bus.burst_o), 256'(wr_exp[k]));
      bus.resp_i = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    check("wr_write_drop", 256'(bus.write_o), 256'(0));
    check("wr_resp_o",     256'(bus.resp_o),  256'(1));
    check("wr_line_keep",  bus.line_o,        rd_line_exp);
    bus.write_i = 1'b0;
    step();
    check("wr_resp_pulse", 256'(bus.resp_o), 256'(0));

    // ---------------- gapped read
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_203F;
    step();
    check("gp_addr_o", 256'(bus.address_o), 256'(32'h0000_2020));
    begin
      int n;
      n = 0;
      for (int p = 0; p < 7; p++) begin
        check("gp_read_held", 256'(bus.read_o), 256'(1));
        check("gp_no_resp",   256'(bus.resp_o), 256'(0));
        bus.resp_i  = gap_pat[p];
        bus.burst_i = gap_pat[p] ? gp_beats[n] : 64'hDEAD_BEEF_DEAD_BEEF;
        if (gap_pat[p]) n++;
        step();
      end
    end
    bus.resp_i = 1'b0;
    check("gp_resp_o", 256'(bus.resp_o), 256'(1));
    check("gp_line_o", bus.line_o,       gp_line_exp);
    bus.read_i = 1'b0;
    step();
    check("gp_single_resp", 256'(bus.resp_o), 256'(0));

    // ---------------- read and write both requested: read wins
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_3000;
    bus.line_i    = wr_line;
    step();
    check("bh_read_o", 256'(bus.read_o), 256'(1));
    for (int k = 0; k < 4; k++) begin
      check("bh_write_o", 256'(bus.write_o), 256'(0));
      bus.resp_i  = 1'b1;
      bus.burst_i = bh_beats[k];
      step();
    end
    bus.resp_i = 1'b0;
    check("bh_resp_o", 256'(bus.resp_o), 256'(1));
    check("bh_line_o", bus.line_o,       bh_line_exp);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    step();

    // ---------------- reset after two write beats
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_0080;
    bus.line_i    = wr_line2;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ab_burst%0d", k), 256'(bus.burst_o), 256'(wr_exp_b[k]));
      bus.resp_i = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    check("ab_write_before", 256'(bus.write_o), 256'(1));
    rst = 1'b0;
    #1;
    check("ab_write_clr", 256'(bus.write_o), 256'(0));
    check("ab_resp_clr",  256'(bus.resp_o),  256'(0));
    bus.write_i = 1'b0;
    step();
    check("ab_no_resp", 256'(bus.resp_o), 256'(0));
    rst = 1'b1;
    step();
    check("ab_no_resp2", 256'(bus.resp_o), 256'(0));
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0100;
    step();
    check("ab_rd_addr", 256'(bus.address_o), 256'(32'h0000_0100));
    for (int k = 0; k < 4; k++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = r2_beats[k];
      step();
    end
    bus.resp_i = 1'b0;
    check("ab_rd_resp", 256'(bus.resp_o), 256'(1));
    check("ab_rd_line", bus.line_o,       r2_line_exp);

    // ---------------- back-to-back: write request presented as resp_o is seen
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b1;
    bus.address_i = 32'h0000_0400;
    bus.line_i    = wr_line;
    step();
    check("b2b_idle_write", 256'(bus.write_o), 256'(0));
    step();
    check("b2b_write_o", 256'(bus.write_o),   256'(1));
    check("b2b_addr_o",  256'(bus.address_o), 256'(32'h0000_0400));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_burst%0d", k), 256'(bus.burst_o), 256'(wr_exp[k]));
      bus.resp_i = 1'b1;
      step();
    end
    bus.resp_i = 1'b0;
    check("b2b_resp_o",    256'(bus.resp_o), 256'(1));
    check("b2b_line_keep", bus.line_o,       r2_line_exp);
    bus.write_i = 1'b0;
    step();
    check("b2b_resp_pulse", 256'(bus.resp_o), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
